// File: rtl/prio_input_decoder.sv
// rtl/prio_input_decoder.sv - fixed-priority get/resume decoder with starvation aging
// Resumes beat gets; a starved get channel beats a plain get; the lowest index wins within each class.
module prio_input_decoder #(
  parameter int NUM_CH     = 4,
  parameter int STARVE_W   = 4,
  parameter int STARVE_MAX = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      decode_en,
  input  logic [NUM_CH-1:0]         ch_valid,
  input  logic [NUM_CH-1:0]         ch_block,
  input  logic [NUM_CH-1:0]         resume_req,
  input  logic                      restrict_en,
  input  logic [NUM_CH-1:0]         restrict_mask,
  output logic [NUM_CH-1:0]         do_get,
  output logic [NUM_CH-1:0]         resume_ack,
  output logic [NUM_CH-1:0]         grant,
  output logic                      grant_is_resume,
  output logic [$clog2(NUM_CH)-1:0] grant_idx,
  output logic                      look,
  output logic [NUM_CH-1:0]         starve_flag
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam logic [STARVE_W-1:0] AGE_MAX = STARVE_W'(STARVE_MAX);
  localparam bit AGING_ON = (STARVE_MAX != 0);

  if (NUM_CH < 2) begin : g_bad_num_ch
    $error("prio_input_decoder: NUM_CH must be at least 2");
  end
  if (STARVE_MAX < 0 || STARVE_MAX >= (1 << STARVE_W)) begin : g_bad_starve_max
    $error("prio_input_decoder: STARVE_MAX must fit in STARVE_W bits");
  end

  logic [NUM_CH-1:0]   can_get_q, can_get_d;
  logic [NUM_CH-1:0]   grant_q, grant_d;
  logic                grant_is_resume_q, grant_is_resume_d;
  logic [IDX_W-1:0]    grant_idx_q, grant_idx_d;
  logic [STARVE_W-1:0] age_q [NUM_CH];
  logic [STARVE_W-1:0] age_d [NUM_CH];

  logic [NUM_CH-1:0] allow, elig_get, elig_res, elig_starve;
  logic [NUM_CH-1:0] win_get, win_res;
  logic              res_hit, starve_hit, get_hit, active;
  logic [IDX_W-1:0]  res_idx, starve_idx, get_idx, win_idx;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      starve_flag[i] = AGING_ON && (age_q[i] == AGE_MAX);
    end
    allow       = ~{NUM_CH{restrict_en}} | restrict_mask;
    elig_get    = can_get_q & ~ch_block & allow;
    elig_res    = resume_req & allow;
    elig_starve = elig_get & starve_flag;
  end

  // Scan from the top down so the lowest eligible index is the one left standing.
  always_comb begin
    res_hit    = 1'b0;
    starve_hit = 1'b0;
    get_hit    = 1'b0;
    res_idx    = '0;
    starve_idx = '0;
    get_idx    = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (elig_res[i]) begin
        res_hit = 1'b1;
        res_idx = IDX_W'(i);
      end
      if (elig_starve[i]) begin
        starve_hit = 1'b1;
        starve_idx = IDX_W'(i);
      end
      if (elig_get[i]) begin
        get_hit = 1'b1;
        get_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    active  = decode_en & ~rst;
    win_res = '0;
    win_get = '0;
    win_idx = '0;
    if (active) begin
      if (res_hit) begin
        win_res[res_idx] = 1'b1;
        win_idx          = res_idx;
      end else if (starve_hit) begin
        win_get[starve_idx] = 1'b1;
        win_idx             = starve_idx;
      end else if (get_hit) begin
        win_get[get_idx] = 1'b1;
        win_idx          = get_idx;
      end
    end
  end

  always_comb begin
    can_get_d         = ch_valid;
    grant_d           = grant_q;
    grant_is_resume_d = grant_is_resume_q;
    grant_idx_d       = grant_idx_q;
    for (int i = 0; i < NUM_CH; i++) begin
      age_d[i] = age_q[i];
    end
    if (decode_en) begin
      grant_d           = win_get | win_res;
      grant_is_resume_d = |win_res;
      grant_idx_d       = win_idx;
      // Blocked or restricted channels with valid data keep their age rather than losing it.
      for (int i = 0; i < NUM_CH; i++) begin
        if (!AGING_ON || win_get[i] || !can_get_q[i]) begin
          age_d[i] = '0;
        end else if (elig_get[i] && age_q[i] != AGE_MAX) begin
          age_d[i] = age_q[i] + STARVE_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      can_get_q         <= '0;
      grant_q           <= '0;
      grant_is_resume_q <= 1'b0;
      grant_idx_q       <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      can_get_q         <= can_get_d;
      grant_q           <= grant_d;
      grant_is_resume_q <= grant_is_resume_d;
      grant_idx_q       <= grant_idx_d;
      for (int i = 0; i < NUM_CH; i++) begin
        age_q[i] <= age_d[i];
      end
    end
  end

  assign do_get          = win_get;
  assign resume_ack      = win_res;
  assign grant           = grant_q;
  assign grant_is_resume = grant_is_resume_q;
  assign grant_idx       = grant_idx_q;
  assign look            = |grant_q;

endmodule

// File: tb/tb_prio_input_decoder.sv
// tb/tb_prio_input_decoder.sv - directed and randomized checks of prio_input_decoder against a channel-level model
module tb_prio_input_decoder;
  localparam int N    = 4;
  localparam int SW   = 2;
  localparam int SMAX = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, decode_en, restrict_en;
  logic [N-1:0] ch_valid, ch_block, resume_req, restrict_mask;
  logic [N-1:0] do_get, resume_ack, grant, starve_flag;
  logic         grant_is_resume, look;
  logic [1:0]   grant_idx;

  int tests = 0;
  int fails = 0;

  // Model state: sampled valids, per-channel age, granted channel (-1 = none).
  bit m_can [N];
  int m_age [N];
  int m_grant_ch;
  bit m_is_res;
  int w_kind;  // 0 none, 1 resume, 2 starved get, 3 plain get
  int w_idx;

  prio_input_decoder #(.NUM_CH(N), .STARVE_W(SW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst), .decode_en(decode_en), .ch_valid(ch_valid),
    .ch_block(ch_block), .resume_req(resume_req), .restrict_en(restrict_en),
    .restrict_mask(restrict_mask), .do_get(do_get), .resume_ack(resume_ack),
    .grant(grant), .grant_is_resume(grant_is_resume), .grant_idx(grant_idx),
    .look(look), .starve_flag(starve_flag)
  );

  function automatic bit allowed(int i);
    return !restrict_en || restrict_mask[i];
  endfunction

  function automatic bit can_pop(int i);
    return m_can[i] && !ch_block[i] && allowed(i);
  endfunction

  task automatic pick(output int kind, output int idx);
    kind = 0;
    idx  = -1;
    if (rst || !decode_en) return;
    for (int i = 0; i < N; i++)
      if (resume_req[i] && allowed(i)) begin kind = 1; idx = i; return; end
    for (int i = 0; i < N; i++)
      if (can_pop(i) && m_age[i] == SMAX) begin kind = 2; idx = i; return; end
    for (int i = 0; i < N; i++)
      if (can_pop(i)) begin kind = 3; idx = i; return; end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic observe();
    logic [N-1:0] e_get, e_ack, e_starve, e_grant;
    #1;
    pick(w_kind, w_idx);
    e_get   = (w_kind >= 2) ? (N'(1) << w_idx) : '0;
    e_ack   = (w_kind == 1) ? (N'(1) << w_idx) : '0;
    e_grant = (m_grant_ch < 0) ? '0 : (N'(1) << m_grant_ch);
    for (int i = 0; i < N; i++) e_starve[i] = (m_age[i] == SMAX);
    chk("do_get", 32'(do_get), 32'(e_get));
    chk("resume_ack", 32'(resume_ack), 32'(e_ack));
    chk("grant", 32'(grant), 32'(e_grant));
    chk("grant_is_resume", 32'(grant_is_resume), 32'(m_is_res));
    chk("grant_idx", 32'(grant_idx), (m_grant_ch < 0) ? 32'd0 : 32'(m_grant_ch));
    chk("look", 32'(look), 32'(m_grant_ch >= 0));
    chk("starve_flag", 32'(starve_flag), 32'(e_starve));
  endtask

  task automatic advance();
    if (rst) begin
      for (int i = 0; i < N; i++) begin m_can[i] = 0; m_age[i] = 0; end
      m_grant_ch = -1;
      m_is_res   = 0;
    end else begin
      if (decode_en) begin
        m_grant_ch = (w_kind == 0) ? -1 : w_idx;
        m_is_res   = (w_kind == 1);
        for (int i = 0; i < N; i++) begin
          if ((w_kind >= 2 && w_idx == i) || !m_can[i]) m_age[i] = 0;
          else if (can_pop(i)) m_age[i] = (m_age[i] + 1 > SMAX) ? SMAX : m_age[i] + 1;
        end
      end
      for (int i = 0; i < N; i++) m_can[i] = ch_valid[i];
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; decode_en = 1'b1; ch_valid = 4'hF; ch_block = '0;
    resume_req = '0; restrict_en = 1'b0; restrict_mask = '0;
    m_grant_ch = -1; m_is_res = 0; w_kind = 0; w_idx = -1;
    @(negedge clk);
    advance();
    observe(); chk("rst_do_get", 32'(do_get), 32'd0); chk("rst_look", 32'(look), 32'd0);
    advance();

    rst = 1'b0;
    observe(); chk("rel1_do_get", 32'(do_get), 32'd0);
    advance();
    ch_valid = 4'b1010;
    observe(); chk("rel2_do_get", 32'(do_get), 32'b0001);
    advance();
    ch_valid = 4'b0001;
    observe(); chk("get1010_do_get", 32'(do_get), 32'b0010);
    advance();
    resume_req = 4'b0100;
    observe();
    chk("get_grant", 32'(grant), 32'b0010);
    chk("get_grant_idx", 32'(grant_idx), 32'd1);
    chk("res_ack", 32'(resume_ack), 32'b0100);
    chk("res_no_get", 32'(do_get), 32'd0);
    advance();
    resume_req = '0;
    observe();
    chk("res_grant", 32'(grant), 32'b0100);
    chk("res_is_resume", 32'(grant_is_resume), 32'd1);
    advance();

    rst = 1'b1; ch_valid = 4'b1001;
    observe(); advance();
    rst = 1'b0;
    observe(); advance();
    for (int d = 1; d <= 5; d++) begin
      observe();
      chk("starve_ch3", 32'(starve_flag[3]), 32'(d == 4));
      chk("starve_do_get", 32'(do_get), (d == 4) ? 32'b1000 : 32'b0001);
      advance();
    end

    rst = 1'b1; ch_valid = 4'b0011; restrict_en = 1'b1; restrict_mask = 4'b0010;
    observe(); advance();
    rst = 1'b0;
    observe(); advance();
    ch_valid = 4'b0001;
    observe(); chk("restrict_do_get", 32'(do_get), 32'b0010);
    advance();
    observe(); chk("restrict_none", 32'(do_get), 32'd0);
    advance();
    observe(); chk("restrict_grant", 32'(grant), 32'd0); chk("restrict_look", 32'(look), 32'd0);
    advance();

    restrict_en = 1'b0; ch_valid = 4'b1001;
    for (int k = 0; k < 3; k++) begin observe(); advance(); end
    decode_en = 1'b0; ch_valid = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      observe();
      chk("hold_do_get", 32'(do_get), 32'd0);
      chk("hold_grant", 32'(grant), 32'b0001);
      advance();
    end
    decode_en = 1'b1;
    observe(); advance();

    for (int k = 0; k < 400; k++) begin
      rst           = ($urandom_range(0, 49) == 0);
      decode_en     = ($urandom_range(0, 5) != 0);
      ch_valid      = 4'($urandom);
      ch_block      = 4'($urandom & $urandom);
      resume_req    = 4'($urandom & $urandom & $urandom);
      restrict_en   = ($urandom_range(0, 4) == 0);
      restrict_mask = 4'($urandom);
      observe();
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/prio_input_decoder.md
PRIO_INPUT_DECODER -- requirements
Module: prio_input_decoder

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of input channels (>=2); index 0 is the highest fixed priority.
REQ-002 SHALL have parameter STARVE_W, default 4, width of the per-channel age counter.
REQ-003 SHALL have parameter STARVE_MAX, default 15, age threshold (< 2^STARVE_W); value 0 disables aging.
REQ-004 SHALL use one clock; reset is synchronous and active-high. Ports are named clk and rst, as elsewhere in the codebase.
REQ-005 clk  input  1  clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 decode_en  input  1  decode strobe; registered state advances only when high.
REQ-008 ch_valid  input  NUM_CH  per-channel input-valid.
REQ-009 ch_block  input  NUM_CH  per-channel stall; blocked channel not eligible for get.
REQ-010 resume_req  input  NUM_CH  per-channel pending resume of a stalled operation.
REQ-011 restrict_en  input  1  restrict arbitration to restrict_mask (recall-style hold).
REQ-012 restrict_mask  input  NUM_CH  channels allowed while restrict_en=1.
REQ-013 do_get  output  NUM_CH  combinational one-hot pop to winning get channel.
REQ-014 resume_ack  output  NUM_CH  combinational one-hot clear to winning resume channel.
REQ-015 grant  output  NUM_CH  registered one-hot winner of last decode; 0 = none.
REQ-016 grant_is_resume  output  1  registered; grant is a resume, not a get.
REQ-017 grant_idx  output  $clog2(NUM_CH)  registered binary index of grant; 0 when none.
REQ-018 look  output  1  OR-reduction of grant.
REQ-019 starve_flag  output  NUM_CH  per channel: age counter == STARVE_MAX (0 when STARVE_MAX=0).

Function
REQ-020 SHALL register can_get <= ch_valid every cycle regardless of decode_en; arbitration uses can_get, not ch_valid (one-cycle sample latency).
REQ-021 allow[i] = ~restrict_en | restrict_mask[i]; elig_get[i] = can_get[i] & ~ch_block[i] & allow[i]; elig_res[i] = resume_req[i] & allow[i].
REQ-022 Winner when decode_en=1, strict order: (a) lowest-index elig_res; else (b) lowest-index elig_get with starve_flag set; else (c) lowest-index elig_get; else none.
REQ-023 do_get SHALL be one-hot of winner in (b)/(c), same cycle, else 0; resume_ack one-hot of winner in (a), else 0; never both nonzero.
REQ-024 do_get and resume_ack SHALL be 0 when decode_en=0 or rst=1.
REQ-025 On clk edge with decode_en=1: grant <= winner one-hot (0 if none), grant_is_resume <= (a) chosen, grant_idx <= winner index (0 if none); with decode_en=0 all three hold.
REQ-026 Age counter per channel, on decode_en=1: cleared when channel wins a get or can_get[i]=0; else incremented (saturating at STARVE_MAX) when elig_get[i]=1 and not granted; else holds.
REQ-027 Age counters SHALL hold when decode_en=0; ch_block or restrict masking freezes (does not clear) a valid channel's counter.
REQ-028 Multiple starved channels: lowest index wins; losers keep saturated counters.
REQ-029 A resume winner SHALL still age all elig_get channels.
REQ-030 Parameter violation (NUM_CH<2, STARVE_MAX>=2^STARVE_W) SHALL fail elaboration.

Reset
REQ-031 With rst=1 at an edge: can_get, grant, grant_is_resume, grant_idx, all age counters <= 0; hence look=0, starve_flag=0, do_get=0, resume_ack=0.
REQ-032 Reset asserted mid-operation SHALL discard any in-flight grant and ages in the same edge; no pop is issued in the reset cycle.

Verification (NUM_CH=4, STARVE_W=2, STARVE_MAX=3)
REQ-033 rst=1 two cycles, ch_valid=4'hF, decode_en=1 -> all outputs 0; first cycle after release do_get=0; second cycle do_get=4'b0001.
REQ-034 can_get=4'b1010, decode_en=1 -> do_get=4'b0010; next cycle grant=4'b0010, grant_idx=1, look=1, grant_is_resume=0.
REQ-035 resume_req=4'b0100, can_get=4'b0001 -> resume_ack=4'b0100, do_get=0; next cycle grant=4'b0100, grant_is_resume=1.
REQ-036 ch0, ch3 valid continuously, decode_en=1 every cycle -> ch0 wins 3 decodes, ch3 age 1,2,3, starve_flag[3]=1; 4th decode do_get=4'b1000, ch3 age->0; 5th ch0 wins.
REQ-037 restrict_en=1, restrict_mask=4'b0010, can_get=4'b0011 -> do_get=4'b0010; then can_get=4'b0001 -> do_get=0, next grant=0, look=0, ch0 age unchanged.
REQ-038 decode_en=0 for 5 cycles with can_get=4'b0001 -> do_get=0, grant, grant_idx, ages hold previous values.
